// File: rtl/accel_bcd_fmt_if.sv
// accel_bcd_fmt_if: sample handshake plus display-driver digit lookup for accel_bcd_fmt.
interface accel_bcd_fmt_if;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] s_x;
    logic [11:0] s_y;
    logic [2:0]  can;
    logic [3:0]  val;
    logic        d;
    logic        valid;
    modport master (output s_valid, s_x, s_y, can, input s_ready, val, d, valid);
    modport slave (input s_valid, s_x, s_y, can, output s_ready, val, d, valid);
endinterface

// File: rtl/accel_bcd_fmt.sv
// accel_bcd_fmt: converts signed X/Y samples to blanked BCD digits via double-dabble.
// Both results commit atomically so the display never shows a mixed pair.
module accel_bcd_fmt (
    input  logic            clk_100mhz,
    input  logic            nrst,
    accel_bcd_fmt_if.slave  bus_io
);
    localparam logic [1:0] IDLE = 2'd0, CONV_X = 2'd1, CONV_Y = 2'd2, COMMIT = 2'd3;
    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] bin_q, bin_d, ymag_q, ymag_d;
    logic [15:0] bcd_q, bcd_d, xbcd_q, xbcd_d;
    logic        xneg_q, xneg_d, yneg_q, yneg_d;
    logic [15:0] disp_x_q, disp_x_d, disp_y_q, disp_y_d;
    logic        dneg_x_q, dneg_x_d, dneg_y_q, dneg_y_d;
    logic [15:0] adj, step_bcd, sel, hi;
    logic [11:0] step_bin;
    logic        last;
    logic [1:0]  idx;
    always_comb begin
        for (int i = 0; i < 4; i++)
            adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        step_bcd = {adj[14:0], bin_q[11]};
        step_bin = {bin_q[10:0], 1'b0};
        last     = cnt_q == 4'd11;
    end
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        ymag_d   = ymag_q;
        xbcd_d   = xbcd_q;
        xneg_d   = xneg_q;
        yneg_d   = yneg_q;
        disp_x_d = disp_x_q;
        disp_y_d = disp_y_q;
        dneg_x_d = dneg_x_q;
        dneg_y_d = dneg_y_q;
        case (state_q)
            IDLE: if (bus_io.s_valid) begin
                state_d = CONV_X;
                bin_d   = bus_io.s_x[11] ? -bus_io.s_x : bus_io.s_x;
                ymag_d  = bus_io.s_y[11] ? -bus_io.s_y : bus_io.s_y;
                xneg_d  = bus_io.s_x[11];
                yneg_d  = bus_io.s_y[11];
                bcd_d   = '0;
                cnt_d   = '0;
            end
            CONV_X: begin
                bcd_d = step_bcd;
                bin_d = step_bin;
                cnt_d = cnt_q + 4'd1;
                // X result parks in xbcd_q while the engine is reused for Y
                if (last) begin
                    xbcd_d  = step_bcd;
                    bcd_d   = '0;
                    bin_d   = ymag_q;
                    cnt_d   = '0;
                    state_d = CONV_Y;
                end
            end
            CONV_Y: begin
                bcd_d   = step_bcd;
                bin_d   = step_bin;
                cnt_d   = cnt_q + 4'd1;
                state_d = last ? COMMIT : CONV_Y;
            end
            default: begin
                disp_x_d = xbcd_q;
                disp_y_d = bcd_q;
                dneg_x_d = xneg_q;
                dneg_y_d = yneg_q;
                state_d  = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk_100mhz or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            ymag_q   <= '0;
            xbcd_q   <= '0;
            xneg_q   <= 1'b0;
            yneg_q   <= 1'b0;
            disp_x_q <= '0;
            disp_y_q <= '0;
            dneg_x_q <= 1'b0;
            dneg_y_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            ymag_q   <= ymag_d;
            xbcd_q   <= xbcd_d;
            xneg_q   <= xneg_d;
            yneg_q   <= yneg_d;
            disp_x_q <= disp_x_d;
            disp_y_q <= disp_y_d;
            dneg_x_q <= dneg_x_d;
            dneg_y_q <= dneg_y_d;
        end
    end
    // A digit is lit when it or any higher digit of its group is nonzero
    assign sel            = bus_io.can[2] ? disp_x_q : disp_y_q;
    assign idx            = bus_io.can[1:0];
    assign hi             = sel >> {idx, 2'b00};
    assign bus_io.val     = hi[3:0];
    assign bus_io.valid   = idx == 2'd0 || |hi;
    assign bus_io.d       = idx == 2'd0 && (bus_io.can[2] ? dneg_x_q : dneg_y_q);
    assign bus_io.s_ready = state_q == IDLE;
endmodule

// File: tb/tb_accel_bcd_fmt.sv
// tb_accel_bcd_fmt: directed scoreboard bench for accel_bcd_fmt.
`timescale 1ns/1ps
module tb_accel_bcd_fmt;
    typedef struct { int x; int y; } pair_t;
    logic clk_100mhz = 0;
    logic nrst = 0;
    int passed = 0;
    int total = 0;
    pair_t sb[$];
    pair_t cur = '{0, 0};
    accel_bcd_fmt_if bus ();
    accel_bcd_fmt dut (.clk_100mhz(clk_100mhz), .nrst(nrst), .bus_io(bus));
    always #10 clk_100mhz = ~clk_100mhz;
    function automatic logic [31:0] model(int x, int y, int c);
        int pw[4] = '{1, 10, 100, 1000};
        int v = c >= 4 ? x : y;
        int m = v < 0 ? -v : v;
        int k = c % 4;
        int dig = (m / pw[k]) % 10;
        logic lit = k == 0 || m >= pw[k];
        logic neg = k == 0 && v < 0;
        return {26'd0, 4'(dig), neg, lit};
    endfunction
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask
    task automatic check_display(pair_t p, string tag);
        for (int c = 0; c < 8; c++) begin
            bus.can = 3'(c);
            #1;
            chk($sformatf("%s(%0d,%0d) can%0d", tag, p.x, p.y, c), {26'd0, bus.val, bus.d, bus.valid}, model(p.x, p.y, c));
        end
    endtask
    task automatic accept(int x, int y, bit hold);
        @(negedge clk_100mhz);
        chk("ready_idle", {31'd0, bus.s_ready}, 1);
        bus.s_valid = 1;
        bus.s_x = 12'(x);
        bus.s_y = 12'(y);
        sb.push_back('{x, y});
        @(posedge clk_100mhz);
        #2;
        if (!hold) bus.s_valid = 0;
    endtask
    task automatic wait_commit();
        int low = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_100mhz);
            if (bus.s_ready) break;
            low++;
            if (low == 25) check_display(cur, "old_before_commit");
        end
        chk("ready_low_cycles", low, 25);
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            check_display(cur, "new");
        end else chk("scoreboard_empty", 0, 1);
    endtask
    initial begin
        bus.s_valid = 0;
        bus.s_x = '0;
        bus.s_y = '0;
        bus.can = '0;
        #5;
        chk("reset_ready", {31'd0, bus.s_ready}, 1);
        check_display('{0, 0}, "reset");
        @(negedge clk_100mhz);
        nrst = 1;
        accept(1234, -5, 0);
        wait_commit();
        accept(-2048, 2047, 0);
        wait_commit();
        accept(100, 0, 0);
        wait_commit();
        accept(-37, 450, 1);
        bus.s_x = 12'(2047);
        bus.s_y = 12'(-2048);
        sb.push_back('{2047, -2048});
        wait_commit();
        @(posedge clk_100mhz);
        #2;
        bus.s_valid = 0;
        bus.s_x = 12'(5);
        bus.s_y = 12'(5);
        wait_commit();
        accept(999, 0, 0);
        repeat (10) @(posedge clk_100mhz);
        #2;
        nrst = 0;
        #1;
        chk("midconv_reset_ready", {31'd0, bus.s_ready}, 1);
        void'(sb.pop_back());
        cur = '{0, 0};
        check_display(cur, "midconv_reset");
        @(negedge clk_100mhz);
        nrst = 1;
        accept(7, -1, 0);
        wait_commit();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
